// File: rtl/loop_sram_ctrl.sv
// Record/play-loop sequencer for the external 1M x 16 async SRAM.
// Records one sample per strobe in REC and replays the loop, wrapping at the recorded length.
module loop_sram_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int MAX_LEN = 1048576,
  parameter int ACC_CYC = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic signed [15:0]       i_data,
  input  logic                     i_key,
  output logic signed [15:0]       o_data,
  output logic                     o_valid,
  output logic [1:0]               o_state,
  output logic [ADDR_W:0]          o_len,
  output logic                     o_overrun,
  output logic [ADDR_W-1:0]        o_SRAM_ADDR,
  inout  wire  [15:0]              io_SRAM_DQ,
  output logic                     o_SRAM_WE_N,
  output logic                     o_SRAM_CE_N,
  output logic                     o_SRAM_OE_N,
  output logic                     o_SRAM_LB_N,
  output logic                     o_SRAM_UB_N
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = 3;
  localparam logic [ADDR_W:0] MAX_LEN_L = (ADDR_W+1)'(MAX_LEN);

  typedef enum logic [1:0] {M_IDLE = 2'd0, M_REC = 2'd1, M_LOOP = 2'd2} mode_e;
  typedef enum logic {A_IDLE = 1'b0, A_BUSY = 1'b1} acc_e;

  mode_e                     mode_q, mode_d;
  acc_e                      acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [ADDR_W-1:0]         sram_addr_q, sram_addr_d;
  logic [ADDR_W:0]           len_q, len_d;
  logic signed [DATA_W-1:0]  data_q, data_d;
  logic signed [DATA_W-1:0]  wdata_q;
  logic                      vld_q, vld_d;
  logic                      ovr_q, ovr_d;
  logic                      pend_q, pend_d;
  logic                      wr_q, wr_d;
  logic                      start;
  logic                      key_now;
  logic                      drv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q      <= M_IDLE;
      acc_q       <= A_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      sram_addr_q <= '0;
      len_q       <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      ovr_q       <= 1'b0;
      pend_q      <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      sram_addr_q <= sram_addr_d;
      len_q       <= len_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      ovr_q       <= ovr_d;
      pend_q      <= pend_d;
      wr_q        <= wr_d;
    end
  end

  // write data is pure datapath; only meaningful while a write is in flight
  always_ff @(posedge i_clk) begin
    if (start) wdata_q <= i_data;
  end

  always_comb begin
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sram_addr_d = sram_addr_q;
    len_d       = len_q;
    data_d      = data_q;
    vld_d       = 1'b0;
    ovr_d       = ovr_q;
    pend_d      = pend_q;
    wr_d        = wr_q;
    start       = 1'b0;
    key_now     = 1'b0;

    if (acc_q == A_IDLE) begin
      if (i_valid && mode_q != M_IDLE) begin
        start       = 1'b1;
        acc_d       = A_BUSY;
        cnt_d       = CNT_W'(ACC_CYC - 1);
        wr_d        = (mode_q == M_REC);
        sram_addr_d = addr_q;
        pend_d      = i_key;
      end else begin
        key_now = i_key;
      end
    end else begin
      if (i_valid) ovr_d = 1'b1;
      if (i_key)   pend_d = 1'b1;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        acc_d   = A_IDLE;
        pend_d  = 1'b0;
        key_now = pend_q | i_key;
        if (wr_q) begin
          addr_d = addr_q + ADDR_W'(1);
          len_d  = {1'b0, addr_q} + (ADDR_W+1)'(1);
          // a full buffer already does what a REC key would: go to LOOP
          if (len_d == MAX_LEN_L) begin
            mode_d  = M_LOOP;
            addr_d  = '0;
            key_now = 1'b0;
          end
        end else begin
          data_d = $signed(io_SRAM_DQ);
          vld_d  = 1'b1;
          addr_d = ({1'b0, addr_q} == len_q - (ADDR_W+1)'(1)) ? '0 : addr_q + ADDR_W'(1);
        end
      end
    end

    if (key_now) begin
      case (mode_q)
        M_IDLE: begin
          mode_d = M_REC;
          addr_d = '0;
          len_d  = '0;
          ovr_d  = 1'b0;
        end
        M_REC: begin
          if (len_d != '0) begin
            mode_d = M_LOOP;
            addr_d = '0;
          end else begin
            mode_d = M_IDLE;
          end
        end
        M_LOOP: begin
          mode_d = M_IDLE;
          data_d = '0;
          vld_d  = 1'b0;
        end
        default: mode_d = M_IDLE;
      endcase
    end
  end

  // strobes derive from the async-reset access state, so reset releases them without a clock
  always_comb begin
    o_SRAM_WE_N = 1'b1;
    o_SRAM_OE_N = 1'b1;
    o_SRAM_CE_N = 1'b1;
    drv         = 1'b0;
    if (acc_q == A_BUSY) begin
      o_SRAM_CE_N = 1'b0;
      if (wr_q) begin
        o_SRAM_WE_N = 1'b0;
        drv         = 1'b1;
      end else begin
        o_SRAM_OE_N = 1'b0;
      end
    end
  end

  assign o_SRAM_LB_N = o_SRAM_CE_N;
  assign o_SRAM_UB_N = o_SRAM_CE_N;
  assign io_SRAM_DQ  = drv ? wdata_q : {DATA_W{1'bz}};
  assign o_SRAM_ADDR = sram_addr_q;
  assign o_data      = data_q;
  assign o_valid     = vld_q;
  assign o_state     = mode_q;
  assign o_len       = len_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_loop_sram_ctrl.sv
// Bench for loop_sram_ctrl: SRAM array model plus a queue-based loop model.
module tb_loop_sram_ctrl;
  localparam int AW = 20;
  localparam int ML = 8;
  localparam int AC = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vld = 1'b0;
  logic               key = 1'b0;
  logic signed [15:0] din = '0;
  logic signed [15:0] dout;
  logic               ovalid;
  logic [1:0]         st;
  logic [AW:0]        len;
  logic               ovr;
  logic [AW-1:0]      sa;
  wire  [15:0]        dq;
  logic               we_n, ce_n, oe_n, lb_n, ub_n;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:255];

  typedef struct {logic [AW-1:0] a; logic [15:0] d; int n; int c;} ev_t;
  ev_t wr_log[$];
  ev_t rd_log[$];
  ev_t vl_log[$];

  int          mode_m = 0;
  logic [15:0] rec_q[$];
  int          play_idx = 0;
  logic        ovr_m = 1'b0;

  loop_sram_ctrl #(.ADDR_W(AW), .MAX_LEN(ML), .ACC_CYC(AC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_data(din), .i_key(key),
    .o_data(dout), .o_valid(ovalid), .o_state(st), .o_len(len), .o_overrun(ovr),
    .o_SRAM_ADDR(sa), .io_SRAM_DQ(dq), .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n),
    .o_SRAM_OE_N(oe_n), .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!we_n && !ce_n) mem[sa[7:0]] <= dq;
  assign dq = (!oe_n && !ce_n) ? mem[sa[7:0]] : 16'hzzzz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bus monitor: logs each SRAM access and each o_valid pulse, checks strobe invariants
  initial begin
    ev_t cw, cr, cv;
    int  wr_run, rd_run;
    wr_run = 0;
    rd_run = 0;
    cw = '{default: 0};
    cr = '{default: 0};
    cv = '{default: 0};
    forever begin
      @(negedge clk);
      if (!we_n) begin
        if (wr_run == 0) begin cw.a = sa; cw.d = dq; cw.c = cyc; end
        wr_run++;
      end else if (wr_run != 0) begin
        cw.n = wr_run; wr_log.push_back(cw); wr_run = 0;
      end
      if (!oe_n) begin
        if (rd_run == 0) begin cr.a = sa; cr.c = cyc; end
        rd_run++;
      end else if (rd_run != 0) begin
        cr.n = rd_run; rd_log.push_back(cr); rd_run = 0;
      end
      if (ovalid) begin cv.d = dout; cv.c = cyc; vl_log.push_back(cv); end
      if (rst_n) begin
        chk("we_oe_excl", 32'(!we_n && !oe_n), 32'd0);
        chk("ce_follows", 32'(ce_n), 32'(we_n & oe_n));
        chk("lb_ub", 32'({lb_n, ub_n}), 32'({ce_n, ce_n}));
        chk("valid_only_loop", 32'(ovalid && st != 2'd2), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    vl_log.delete();
  endtask

  task automatic check_mode();
    chk("state", 32'(st), 32'(mode_m));
    chk("len", 32'(len), 32'(rec_q.size()));
    chk("overrun", 32'(ovr), 32'(ovr_m));
  endtask

  task automatic do_key();
    int prev;
    prev = mode_m;
    key = 1'b1; tick(); key = 1'b0;
    case (mode_m)
      0: begin mode_m = 1; rec_q.delete(); ovr_m = 1'b0; end
      1: begin mode_m = (rec_q.size() > 0) ? 2 : 0; play_idx = 0; end
      default: mode_m = 0;
    endcase
    check_mode();
    if (prev == 2) chk("data_cleared", 32'(dout), 32'd0);
  endtask

  task automatic do_strobe(input logic [15:0] d, input int gap);
    int  sc;
    ev_t e;
    sc = cyc;
    din = d; vld = 1'b1; tick(); vld = 1'b0;
    repeat (3 + gap) tick();
    if (mode_m == 0) begin
      chk("idle_no_wr", 32'(wr_log.size()), 32'd0);
      chk("idle_no_rd", 32'(rd_log.size()), 32'd0);
      chk("idle_no_vld", 32'(vl_log.size()), 32'd0);
    end else if (mode_m == 1) begin
      chk("wr_count", 32'(wr_log.size()), 32'd1);
      chk("rec_no_vld", 32'(vl_log.size()), 32'd0);
      if (wr_log.size() > 0) begin
        e = wr_log.pop_front();
        chk("wr_addr", 32'(e.a), 32'(rec_q.size()));
        chk("wr_data", 32'(e.d), 32'(d));
        chk("wr_width", 32'(e.n), 32'(AC));
      end
      rec_q.push_back(d);
      if (rec_q.size() == ML) begin mode_m = 2; play_idx = 0; end
    end else begin
      chk("rd_count", 32'(rd_log.size()), 32'd1);
      chk("vld_count", 32'(vl_log.size()), 32'd1);
      if (rd_log.size() > 0) begin
        e = rd_log.pop_front();
        chk("rd_addr", 32'(e.a), 32'(play_idx));
        chk("rd_width", 32'(e.n), 32'(AC));
      end
      if (vl_log.size() > 0) begin
        e = vl_log.pop_front();
        chk("play_data", 32'(e.d), 32'(rec_q[play_idx]));
        chk("rd_latency", 32'(e.c - sc), 32'(AC + 1));
      end
      play_idx = (play_idx + 1) % rec_q.size();
    end
    clear_logs();
    check_mode();
  endtask

  initial begin
    ev_t e;
    int  n;
    logic [15:0] r;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_data", 32'(dout), 32'd0);
    chk("rst_valid", 32'(ovalid), 32'd0);
    chk("rst_len", 32'(len), 32'd0);
    chk("rst_overrun", 32'(ovr), 32'd0);
    chk("rst_addr", 32'(sa), 32'd0);
    chk("rst_ctrls", 32'({we_n, ce_n, oe_n, lb_n, ub_n}), 32'h1f);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) do_strobe(16'($urandom), 0);

    do_key();
    for (int i = 1; i <= 4; i++) do_strobe(16'(i), 0);
    do_key();
    chk("len_four", 32'(len), 32'd4);
    for (int i = 0; i < 10; i++) do_strobe(16'($urandom), 0);
    do_key();

    // back-to-back strobes: the second lands while the write is busy
    do_key();
    r = 16'($urandom);
    din = r; vld = 1'b1; tick(); tick(); vld = 1'b0;
    repeat (3) tick();
    chk("ovr_wr_count", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) begin
      e = wr_log.pop_front();
      chk("ovr_wr_addr", 32'(e.a), 32'd0);
      chk("ovr_wr_data", 32'(e.d), 32'(r));
    end
    rec_q.push_back(r);
    ovr_m = 1'b1;
    clear_logs();
    check_mode();
    do_key();
    do_strobe(16'($urandom), 0);
    do_strobe(16'($urandom), 1);
    do_key();
    do_key();
    do_key();
    chk("empty_rec_len", 32'(len), 32'd0);

    // recording past MAX_LEN switches to playback by itself
    do_key();
    for (int i = 0; i < 10; i++) do_strobe(16'($urandom), 0);
    chk("auto_state", 32'(st), 32'd2);
    chk("auto_len", 32'(len), 32'(ML));

    // key during a read: the read completes, sample is dropped, mode goes IDLE
    n = play_idx;
    din = 16'($urandom); vld = 1'b1; tick(); vld = 1'b0;
    key = 1'b1; tick(); key = 1'b0;
    repeat (3) tick();
    chk("pk_rd_count", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() > 0) begin
      e = rd_log.pop_front();
      chk("pk_rd_addr", 32'(e.a), 32'(n));
    end
    chk("pk_no_vld", 32'(vl_log.size()), 32'd0);
    chk("pk_data", 32'(dout), 32'd0);
    mode_m = 0;
    clear_logs();
    check_mode();

    // random loop; last sample arrives with the key, and a second key is ignored
    do_key();
    n = int'($urandom_range(2, 6));
    for (int i = 0; i < n - 1; i++) do_strobe(16'($urandom), int'($urandom_range(0, 2)));
    r = 16'($urandom);
    din = r; vld = 1'b1; key = 1'b1; tick(); vld = 1'b0;
    tick(); key = 1'b0;
    repeat (3) tick();
    chk("sk_wr_count", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) begin
      e = wr_log.pop_front();
      chk("sk_wr_addr", 32'(e.a), 32'(n - 1));
      chk("sk_wr_data", 32'(e.d), 32'(r));
    end
    rec_q.push_back(r);
    mode_m = 2;
    play_idx = 0;
    clear_logs();
    check_mode();
    n = int'($urandom_range(6, 14));
    for (int i = 0; i < n; i++) do_strobe(16'($urandom), int'($urandom_range(0, 3)));

    // asynchronous reset in the middle of a write
    do_key();
    do_key();
    din = 16'($urandom); vld = 1'b1; tick(); vld = 1'b0;
    chk("mid_we_low", 32'(we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we", 32'(we_n), 32'd1);
    chk("async_ce", 32'(ce_n), 32'd1);
    chk("async_oe", 32'(oe_n), 32'd1);
    chk("async_state", 32'(st), 32'd0);
    chk("async_len", 32'(len), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    mode_m = 0;
    rec_q.delete();
    ovr_m = 1'b0;
    do_strobe(16'($urandom), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
